// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if : CPU data-port bus between the core (master) and dmem_responder
// Optional: DMEM_BYTE_WRITE_EN adds the byte_en lane mask.
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface dmem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        wren;
  logic [31:0] mem_read_data;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  byte_en;
`endif

`ifdef DMEM_BYTE_WRITE_EN
  modport master (output mem_addr, mem_write_data, wren, byte_en, input mem_read_data);
  modport slave  (input mem_addr, mem_write_data, wren, byte_en, output mem_read_data);
`else
  modport master (output mem_addr, mem_write_data, wren, input mem_read_data);
  modport slave  (input mem_addr, mem_write_data, wren, output mem_read_data);
`endif
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder : data RAM plus LED / cycle counter / compare timer I/O block
// Optional: DMEM_BYTE_WRITE_EN enables per-byte RAM write masking.
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int LED_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_if.slave            bus,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  localparam logic [15:0] c_off_led   = 16'h0000;
  localparam logic [15:0] c_off_cycle = 16'h0004;
  localparam logic [15:0] c_off_tcmp  = 16'h0008;
  localparam logic [15:0] c_off_tctrl = 16'h000C;
  localparam logic [15:0] c_off_tcnt  = 16'h0010;

  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_rd_data;
  logic [LED_W-1:0]  r_led;
  logic [31:0]       r_cycle;
  logic [31:0]       r_tcmp;
  logic [31:0]       r_tcnt;
  logic              r_en;
  logic              r_flag;
  logic              r_ie;

  logic              w_io_sel;
  logic [ADDR_W-1:0] w_idx;
  logic [15:0]       w_off;
  logic              w_io_wr;
  logic              w_wr_led;
  logic              w_wr_tcmp;
  logic              w_wr_tctrl;
  logic              w_wr_tcnt;
  logic              w_match;
  logic [31:0]       w_io_rd;
  logic [31:0]       w_ram_rd;

  assign w_io_sel   = (bus.mem_addr[31:16] == 16'hFFFF);
  assign w_idx      = bus.mem_addr[ADDR_W+1:2];
  assign w_off      = bus.mem_addr[15:0];
  assign w_io_wr    = bus.wren & w_io_sel;
  assign w_wr_led   = w_io_wr & (w_off == c_off_led);
  assign w_wr_tcmp  = w_io_wr & (w_off == c_off_tcmp);
  assign w_wr_tctrl = w_io_wr & (w_off == c_off_tctrl);
  assign w_wr_tcnt  = w_io_wr & (w_off == c_off_tcnt);
  assign w_match    = r_en & (r_tcnt == r_tcmp);

  // RAM is not reset; the rst qualifier drops a write landing while reset is held.
  always_ff @(posedge clk) begin
    if (rst && bus.wren && !w_io_sel) begin
`ifdef DMEM_BYTE_WRITE_EN
      for (int i = 0; i < 4; i++) begin
        if (bus.byte_en[i]) r_mem[w_idx][8*i +: 8] <= bus.mem_write_data[8*i +: 8];
      end
`else
      r_mem[w_idx] <= bus.mem_write_data;
`endif
    end
  end

  assign w_ram_rd = r_mem[w_idx];

  always_comb begin
    w_io_rd = 32'd0;
    case (w_off)
      c_off_led:   w_io_rd = 32'(r_led);
      c_off_cycle: w_io_rd = r_cycle;
      c_off_tcmp:  w_io_rd = r_tcmp;
      c_off_tctrl: w_io_rd = {29'd0, r_ie, r_flag, r_en};
      c_off_tcnt:  w_io_rd = r_tcnt;
      default:     w_io_rd = 32'd0;
    endcase
  end

  // Reads sample pre-edge register state, giving read-first behaviour everywhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= 32'd0;
    end else begin
      r_rd_data <= w_io_sel ? w_io_rd : w_ram_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led   <= '0;
      r_cycle <= 32'd0;
      r_tcmp  <= 32'd0;
      r_tcnt  <= 32'd0;
      r_en    <= 1'b0;
      r_flag  <= 1'b0;
      r_ie    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_wr_led)  r_led  <= bus.mem_write_data[LED_W-1:0];
      if (w_wr_tcmp) r_tcmp <= bus.mem_write_data;
      if (w_wr_tctrl) begin
        r_en <= bus.mem_write_data[0];
        r_ie <= bus.mem_write_data[2];
      end
      // A match in the same cycle as a write-1-to-clear keeps the flag set.
      if (w_match) begin
        r_flag <= 1'b1;
      end else if (w_wr_tctrl && bus.mem_write_data[1]) begin
        r_flag <= 1'b0;
      end
      if (w_wr_tcnt) begin
        r_tcnt <= bus.mem_write_data;
      end else if (w_match) begin
        r_tcnt <= 32'd0;
      end else if (r_en) begin
        r_tcnt <= r_tcnt + 32'd1;
      end
    end
  end

  assign bus.mem_read_data = r_rd_data;
  assign led               = r_led;
  assign timer_irq         = r_flag & r_ie;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder : directed self-checking bench for dmem_responder
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] led;
  logic        timer_irq;
  int          checks;
  int          failures;
  int unsigned edges;

  dmem_if bus ();

  dmem_responder #(.ADDR_W(10), .LED_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .led       (led),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen with reset released; CYCLE read at an edge equals edges-1 afterwards.
  always @(posedge clk) edges <= rst ? edges + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] addr, input logic [31:0] data, input logic we);
    bus.mem_addr       = addr;
    bus.mem_write_data = data;
    bus.wren           = we;
    @(posedge clk);
    #1;
    bus.wren = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edges    = 0;
    rst      = 1'b0;
    bus.mem_addr       = 32'd0;
    bus.mem_write_data = 32'd0;
    bus.wren           = 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
    bus.byte_en        = 4'hF;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", bus.mem_read_data, 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_irq", 32'(timer_irq), 32'd0);
    rst = 1'b1;

    // RAM write, read, alias
    cyc(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    cyc(32'h0000_0010, 32'd0, 1'b0);
    chk("ram_read", bus.mem_read_data, 32'hDEAD_BEEF);
    cyc(32'h0000_1010, 32'd0, 1'b0);
    chk("ram_alias", bus.mem_read_data, 32'hDEAD_BEEF);

    // Read-first on same-edge write
    cyc(32'h0000_0010, 32'h1234_5678, 1'b1);
    chk("ram_read_first", bus.mem_read_data, 32'hDEAD_BEEF);
    cyc(32'h0000_0010, 32'd0, 1'b0);
    chk("ram_new_value", bus.mem_read_data, 32'h1234_5678);

    // LED and unmapped I/O
    cyc(32'hFFFF_0000, 32'h0001_A5A5, 1'b1);
    chk("led_out", 32'(led), 32'h0000_A5A5);
    chk("led_read_first", bus.mem_read_data, 32'd0);
    cyc(32'hFFFF_0000, 32'd0, 1'b0);
    chk("led_read", bus.mem_read_data, 32'h0000_A5A5);
    cyc(32'hFFFF_0020, 32'hFFFF_FFFF, 1'b1);
    cyc(32'hFFFF_0020, 32'd0, 1'b0);
    chk("unmapped_read", bus.mem_read_data, 32'd0);

    // CYCLE counts through a write attempt
    cyc(32'hFFFF_0004, 32'd0, 1'b0);
    chk("cycle_read", bus.mem_read_data, edges - 1);
    cyc(32'hFFFF_0004, 32'h0000_0000, 1'b1);
    chk("cycle_wr_ignored_a", bus.mem_read_data, edges - 1);
    cyc(32'hFFFF_0004, 32'd0, 1'b0);
    chk("cycle_wr_ignored_b", bus.mem_read_data, edges - 1);

    // Timer: TCMP=3, EN+IE, TCNT sequence 0,1,2,3,0
    cyc(32'hFFFF_0008, 32'd3, 1'b1);
    cyc(32'hFFFF_000C, 32'h5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(32'hFFFF_0010, 32'd0, 1'b0);
      chk($sformatf("tcnt_seq%0d", i), bus.mem_read_data, (i == 4) ? 32'd0 : 32'(i));
      chk($sformatf("irq_seq%0d", i), 32'(timer_irq), (i >= 3) ? 32'd1 : 32'd0);
    end
    cyc(32'hFFFF_000C, 32'd0, 1'b0);
    chk("tctrl_read", bus.mem_read_data, 32'h7);
    cyc(32'hFFFF_000C, 32'h7, 1'b1);
    chk("flag_clear_irq", 32'(timer_irq), 32'd0);
    cyc(32'hFFFF_000C, 32'h7, 1'b1);
    chk("set_beats_clear_irq", 32'(timer_irq), 32'd1);
    cyc(32'hFFFF_000C, 32'd0, 1'b0);
    chk("set_beats_clear_reg", bus.mem_read_data, 32'h7);
    cyc(32'hFFFF_0010, 32'd2, 1'b1);
    cyc(32'hFFFF_0010, 32'd0, 1'b0);
    chk("tcnt_write_priority", bus.mem_read_data, 32'd2);

    // Run to roughly cycle 50, then reset mid-cycle with a RAM write pending
    while (edges < 50) cyc(32'hFFFF_0004, 32'd0, 1'b0);
    chk("cycle_before_reset", bus.mem_read_data, edges - 1);
    chk("irq_before_reset", 32'(timer_irq), 32'd1);
    bus.mem_addr       = 32'h0000_0010;
    bus.mem_write_data = 32'hBAD0_BAD0;
    bus.wren           = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_rd", bus.mem_read_data, 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_irq", 32'(timer_irq), 32'd0);
    @(posedge clk);
    #1;
    bus.wren = 1'b0;
    rst      = 1'b1;
    cyc(32'h0000_0010, 32'd0, 1'b0);
    chk("ram_kept_write_lost", bus.mem_read_data, 32'h1234_5678);
    cyc(32'hFFFF_0004, 32'd0, 1'b0);
    chk("cycle_restart", bus.mem_read_data, 32'd1);
    cyc(32'hFFFF_0010, 32'd0, 1'b0);
    chk("tcnt_after_reset", bus.mem_read_data, 32'd0);
    cyc(32'hFFFF_000C, 32'd0, 1'b0);
    chk("tctrl_after_reset", bus.mem_read_data, 32'd0);

`ifdef DMEM_BYTE_WRITE_EN
    bus.byte_en = 4'hF;
    cyc(32'h0000_0020, 32'h1122_3344, 1'b1);
    bus.byte_en = 4'b0101;
    cyc(32'h0000_0020, 32'hAABB_CCDD, 1'b1);
    cyc(32'h0000_0020, 32'd0, 1'b0);
    chk("byte_en_0101", bus.mem_read_data, 32'h11BB_33DD);
    bus.byte_en = 4'b0000;
    cyc(32'h0000_0020, 32'hFFFF_FFFF, 1'b1);
    cyc(32'h0000_0020, 32'd0, 1'b0);
    chk("byte_en_0000", bus.mem_read_data, 32'h11BB_33DD);
    cyc(32'hFFFF_0008, 32'hCAFE_F00D, 1'b1);
    cyc(32'hFFFF_0008, 32'd0, 1'b0);
    chk("io_ignores_byte_en", bus.mem_read_data, 32'hCAFE_F00D);
    bus.byte_en = 4'hF;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data port. It receives the address, write data and write enable driven by the CPU, and returns read data.
- Contains a word-addressed data RAM and a small memory-mapped I/O block: LED register, free-running cycle counter, and a compare timer with a sticky flag and interrupt.
- Sits beside the CPU core at top level. Its outputs feed the CPU's mem_read_data input and board LEDs.

Parameters:
- ADDR_W, 10, RAM word-address width; RAM depth = 2^ADDR_W 32-bit words.
- LED_W, 16, width of LED output register.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_addr  input  32  byte address from CPU.
- mem_write_data  input  32  write data from CPU.
- wren  input  1  write enable; 1 = write this cycle.
- mem_read_data  output  32  registered read data to CPU.
- led  output  LED_W  LED register contents.
- timer_irq  output  1  timer interrupt, level.

Behaviour:
- Decode:
  - mem_addr[31:16]==16'hFFFF selects I/O; all other addresses select RAM.
  - RAM word index = mem_addr[ADDR_W+1:2]. mem_addr[1:0] and the upper unused bits are ignored, so the RAM aliases.
- RAM write: on a clk rise with wren=1 and RAM selected, word[index] <= mem_write_data.
- Read latency: 1 cycle.
  - mem_read_data is registered on each clk rise from the address present at that edge, whether or not wren is asserted.
  - Same-edge read and write to the same location returns the OLD value (read-first), for both RAM and I/O.
- I/O map (offset = mem_addr[15:0]):
  - 0x0000 LED: RW. Holds LED_W bits; reads are zero-extended.
  - 0x0004 CYCLE: RO. 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF -> 0. Writes ignored.
  - 0x0008 TCMP: RW, 32-bit compare value.
  - 0x000C TCTRL:
    - bit0 EN, RW.
    - bit1 FLAG: sticky; write 1 clears, write 0 has no effect.
    - bit2 IE, RW.
    - Other bits read 0.
  - 0x0010 TCNT: RW. A write loads the counter.
  - Any other I/O offset reads 0; writes are ignored.
- Timer:
  - When EN=1, each cycle: if TCNT==TCMP, then TCNT <= 0 and FLAG <= 1; otherwise TCNT <= TCNT+1.
  - When EN=0, TCNT holds.
  - A CPU write to TCNT has priority over count/reset in the same cycle.
  - If FLAG set and FLAG clear occur in the same cycle, set wins.
  - timer_irq = FLAG & IE, driven combinationally from registers (glitch-free).
- Reset (rst=0, asynchronous) sets mem_read_data=0, led=0, CYCLE=0, TCMP=0, TCTRL=0, TCNT=0, timer_irq=0.
  - RAM contents are not reset.
  - Deassertion is synchronous to clk, handled at top level.
- Reset mid-operation: a write in the cycle where rst asserts is lost. Counters restart from 0 after release.

Optional Feature:
- Macro DMEM_BYTE_WRITE_EN.
- Defined:
  - Adds input port byte_en (4 bits), valid with wren.
  - RAM writes update only the lanes whose byte_en bit is 1; bit i covers bits [8i+7:8i].
  - byte_en=0000 with wren=1 leaves RAM unchanged.
  - I/O writes ignore byte_en and always write the full word.
- Undefined: no byte_en port; every RAM write is a full 32-bit word.

Test Plan:
1. RAM write/read:
   - Write 0xDEADBEEF to 0x00000010, then read 0x00000010 next cycle -> mem_read_data=0xDEADBEEF one cycle after the read address.
   - Read 0x00001010 with ADDR_W=10 -> aliases to the same word, 0xDEADBEEF.
2. Read-first: hold 0x00000010 with wren=1 and data 0x12345678 (old value 0xDEADBEEF) -> mem_read_data=0xDEADBEEF after that edge, then 0x12345678 on the next edge.
3. LED and unmapped I/O:
   - Write 0x0001A5A5 to 0xFFFF0000 -> led=0xA5A5, read returns 0x0000A5A5.
   - Read 0xFFFF0020 -> 0.
   - Write to 0xFFFF0004 -> CYCLE keeps counting.
4. Timer:
   - Write TCMP=3, then TCTRL=0b101 -> TCNT runs 0,1,2,3,0.
   - FLAG=1 and timer_irq=1 on the cycle after TCNT==3.
   - Writing TCTRL=0b111 clears FLAG and timer_irq drops. If the clear coincides with a match, FLAG stays 1.
5. Reset mid-count: with the timer running and CYCLE ≈ 50, assert rst for 1 cycle -> all outputs and registers are 0 immediately, before any clk edge. Previously written RAM data still reads back.
6. (DMEM_BYTE_WRITE_EN) Word holds 0x11223344; write 0xAABBCCDD with byte_en=0101 -> reads 0x11BB33DD.
